time_set_ampm: RTL and testbench

TIME_SET_AMPM -- requirements
Module: time_set_ampm

---
 rtl/time_set_ampm.sv | 218 +++++++++++++++++++++
 tb/tb_time_set_ampm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ampm.sv
// time_set_ampm: interactive time-setting controller with 12h/24h editing.
//
// The block captures the running 24h BCD time when set_mode rises, lets the
// user step the hour, minute, second and (in 12h mode) meridiem fields with
// debounced buttons, and commits the result back as 24h BCD.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   toggle_ampm  1 = edit in 12h AM/PM format, 0 = edit in 24h format
//   set_mode     level request to edit; a rising edge starts an edit, low aborts
//   btn_next     advance to the next field (priority over inc/dec)
//   btn_inc      increment the current field
//   btn_dec      decrement the current field
//   BCD_cur      running time {hT,hU,mT,mU,sT,sU}, 24h BCD
//   BCD_load     committed time, 24h BCD, held until the next commit
//   load_valid   one-cycle strobe qualifying BCD_load
//   editing      high in every EDIT_* state
//   field_sel    0 hour, 1 minute, 2 second, 3 meridiem (0 outside editing)
//   BCD_edit     value under edit, in the format selected by toggle_ampm
//   pm_edit      meridiem under edit (0 in 24h format)
module time_set_ampm (
  input  logic        clk,
  input  logic        rst,
  input  logic        toggle_ampm,
  input  logic        set_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] BCD_cur,
  output logic [23:0] BCD_load,
  output logic        load_valid,
  output logic        editing,
  output logic [1:0]  field_sel,
  output logic [23:0] BCD_edit,
  output logic        pm_edit
);

  typedef enum logic [2:0] {
    IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, EDIT_MER, COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  h12_q, h12_d;
  logic        pm_q, pm_d;
  logic [7:0]  mm_q, mm_d;
  logic [7:0]  ss_q, ss_d;
  logic [23:0] load_q, load_d;
  logic        lv_q, lv_d;
  logic        sm_q, sm_d;
  logic        armed_q, armed_d;

  logic        rise;
  logic        step;
  logic        cap_valid;
  logic [4:0]  cap_h24;
  logic [4:0]  hour24;
  logic [4:0]  h24_next;
  logic [4:0]  hb12;
  logic [4:0]  h12_next;
  logic [7:0]  hour24_bcd;

  // Two-digit BCD (value <= 29) to binary.
  function automatic logic [4:0] bcd2bin(input logic [7:0] b);
    return ({1'b0, b[7:4]} * 5'd10) + {1'b0, b[3:0]};
  endfunction

  // Binary 0..29 to two-digit BCD.
  function automatic logic [7:0] bin2bcd(input logic [4:0] v);
    logic [1:0] t;
    t = (v >= 5'd20) ? 2'd2 : (v >= 5'd10) ? 2'd1 : 2'd0;
    return {2'b00, t, v[3:0] - ({2'b00, t} * 4'd10)};
  endfunction

  // 24h binary hour to {pm, 12h BCD hour}; out-of-range maps to 12 AM.
  function automatic logic [8:0] h24_to_12(input logic [4:0] h);
    if (h == 5'd0 || h > 5'd23) return {1'b0, 8'h12};
    else if (h < 5'd12)         return {1'b0, bin2bcd(h)};
    else if (h == 5'd12)        return {1'b1, 8'h12};
    else                        return {1'b1, bin2bcd(h - 5'd12)};
  endfunction

  // 12h BCD hour plus meridiem to 24h binary hour.
  function automatic logic [4:0] h12_to_24(input logic [7:0] h12, input logic pm);
    logic [4:0] hb;
    hb = bcd2bin(h12);
    if (hb == 5'd12) return pm ? 5'd12 : 5'd0;
    else             return pm ? hb + 5'd12 : hb;
  endfunction

  // Minute/second BCD step with digit carry/borrow, wrapping 59 <-> 00.
  function automatic logic [7:0] bcd60_step(input logic [7:0] v, input logic up);
    if (up) begin
      if (v[3:0] >= 4'd9) return {(v[7:4] >= 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v[3:0] == 4'd0) return {(v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
    end
  endfunction

  // armed_q keeps a set_mode that is already high when reset lifts from
  // counting as a fresh rising edge.
  assign rise = set_mode & ~sm_q & armed_q;
  assign step = btn_inc ^ btn_dec;

  assign cap_valid  = (BCD_cur[23:20] <= 4'd2) && (BCD_cur[19:16] <= 4'd9);
  assign cap_h24    = cap_valid ? bcd2bin(BCD_cur[23:16]) : 5'd0;
  assign hour24     = h12_to_24(h12_q, pm_q);
  assign hour24_bcd = bin2bcd(hour24);
  assign hb12       = bcd2bin(h12_q);

  always_comb begin
    h24_next = '0;
    h12_next = '0;
    if (btn_inc) begin
      h24_next = (hour24 >= 5'd23) ? 5'd0 : hour24 + 5'd1;
      h12_next = (hb12 >= 5'd12) ? 5'd1 : hb12 + 5'd1;
    end else begin
      h24_next = (hour24 == 5'd0) ? 5'd23 : hour24 - 5'd1;
      h12_next = (hb12 <= 5'd1) ? 5'd12 : hb12 - 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    h12_d   = h12_q;
    pm_d    = pm_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    load_d  = load_q;
    lv_d    = 1'b0;
    sm_d    = set_mode;
    armed_d = armed_q | ~set_mode;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d       = EDIT_HOUR;
          {pm_d, h12_d} = h24_to_12(cap_h24);
          mm_d          = BCD_cur[15:8];
          ss_d          = BCD_cur[7:0];
        end
      end
      EDIT_HOUR: begin
        if (!set_mode)     state_d = IDLE;
        else if (btn_next) state_d = EDIT_MIN;
        else if (step) begin
          if (toggle_ampm) h12_d = bin2bcd(h12_next);
          else             {pm_d, h12_d} = h24_to_12(h24_next);
        end
      end
      EDIT_MIN: begin
        if (!set_mode)     state_d = IDLE;
        else if (btn_next) state_d = EDIT_SEC;
        else if (step)     mm_d = bcd60_step(mm_q, btn_inc);
      end
      EDIT_SEC: begin
        if (!set_mode)     state_d = IDLE;
        else if (btn_next) state_d = toggle_ampm ? EDIT_MER : COMMIT;
        else if (step)     ss_d = bcd60_step(ss_q, btn_inc);
      end
      EDIT_MER: begin
        if (!set_mode)                 state_d = IDLE;
        else if (btn_next)             state_d = COMMIT;
        else if (step && toggle_ampm)  pm_d = ~pm_q;
      end
      COMMIT: begin
        state_d = IDLE;
        lv_d    = 1'b1;
        load_d  = {hour24_bcd, mm_q, ss_q};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h12_q   <= 8'h12;
      pm_q    <= 1'b0;
      mm_q    <= '0;
      ss_q    <= '0;
      load_q  <= '0;
      lv_q    <= 1'b0;
      sm_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h12_q   <= h12_d;
      pm_q    <= pm_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      load_q  <= load_d;
      lv_q    <= lv_d;
      sm_q    <= sm_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    editing   = 1'b0;
    field_sel = 2'd0;
    unique case (state_q)
      EDIT_HOUR: begin editing = 1'b1; field_sel = 2'd0; end
      EDIT_MIN:  begin editing = 1'b1; field_sel = 2'd1; end
      EDIT_SEC:  begin editing = 1'b1; field_sel = 2'd2; end
      EDIT_MER:  begin editing = 1'b1; field_sel = 2'd3; end
      default:   begin editing = 1'b0; field_sel = 2'd0; end
    endcase
  end

  assign BCD_edit   = toggle_ampm ? {h12_q, mm_q, ss_q} : {hour24_bcd, mm_q, ss_q};
  assign pm_edit    = toggle_ampm & pm_q;
  assign BCD_load   = load_q;
  assign load_valid = lv_q;

endmodule

// File: tb/tb_time_set_ampm.sv
module tb_time_set_ampm;

  logic        clk = 1'b0;
  logic        rst;
  logic        toggle_ampm;
  logic        set_mode;
  logic        btn_next;
  logic        btn_inc;
  logic        btn_dec;
  logic [23:0] BCD_cur;
  logic [23:0] BCD_load;
  logic        load_valid;
  logic        editing;
  logic [1:0]  field_sel;
  logic [23:0] BCD_edit;
  logic        pm_edit;

  int tests = 0;
  int fails = 0;

  time_set_ampm dut (
    .clk(clk), .rst(rst), .toggle_ampm(toggle_ampm), .set_mode(set_mode),
    .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .BCD_cur(BCD_cur), .BCD_load(BCD_load), .load_valid(load_valid),
    .editing(editing), .field_sel(field_sel), .BCD_edit(BCD_edit),
    .pm_edit(pm_edit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic n, input logic i, input logic d);
    btn_next = n; btn_inc = i; btn_dec = d;
    tick();
    btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; toggle_ampm = 1'b1; set_mode = 1'b0;
    btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; BCD_cur = '0;
    tick();
    tests++; if (editing !== 1'b0) begin fails++; $display("FAIL reset_editing: got %b want 0", editing); end
    tests++; if (field_sel !== 2'd0) begin fails++; $display("FAIL reset_field: got %0d want 0", field_sel); end
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL reset_lv: got %b want 0", load_valid); end
    tests++; if (BCD_load !== 24'h000000) begin fails++; $display("FAIL reset_load: got %h want 000000", BCD_load); end
    tests++; if (BCD_edit !== 24'h120000) begin fails++; $display("FAIL reset_edit12: got %h want 120000", BCD_edit); end
    tests++; if (pm_edit !== 1'b0) begin fails++; $display("FAIL reset_pm: got %b want 0", pm_edit); end
    toggle_ampm = 1'b0; #1;
    tests++; if (BCD_edit !== 24'h000000) begin fails++; $display("FAIL reset_edit24: got %h want 000000", BCD_edit); end
    rst = 1'b0; toggle_ampm = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    toggle_ampm = 1'b1; BCD_cur = 24'h000000; set_mode = 1'b1;
    tick();
    tests++; if (editing !== 1'b1) begin fails++; $display("FAIL cap_editing: got %b want 1", editing); end
    tests++; if (field_sel !== 2'd0) begin fails++; $display("FAIL cap_field: got %0d want 0", field_sel); end
    tests++; if (BCD_edit !== 24'h120000) begin fails++; $display("FAIL cap_edit: got %h want 120000", BCD_edit); end
    tests++; if (pm_edit !== 1'b0) begin fails++; $display("FAIL cap_pm: got %b want 0", pm_edit); end
    set_mode = 1'b0;
    tick();
    tests++; if (editing !== 1'b0) begin fails++; $display("FAIL cap_abort: got %b want 0", editing); end
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL cap_abort_lv: got %b want 0", load_valid); end
  endtask

  task automatic test_ampm_commit();
    toggle_ampm = 1'b1; BCD_cur = 24'h215930; set_mode = 1'b1;
    tick();
    tests++; if (BCD_edit !== 24'h095930) begin fails++; $display("FAIL pm_cap_edit: got %h want 095930", BCD_edit); end
    tests++; if (pm_edit !== 1'b1) begin fails++; $display("FAIL pm_cap_pm: got %b want 1", pm_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    tests++; if (field_sel !== 2'd1) begin fails++; $display("FAIL pm_field_min: got %0d want 1", field_sel); end
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h090030) begin fails++; $display("FAIL pm_min_wrap: got %h want 090030", BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    tests++; if (field_sel !== 2'd3) begin fails++; $display("FAIL pm_field_mer: got %0d want 3", field_sel); end
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (pm_edit !== 1'b0) begin fails++; $display("FAIL pm_mer_toggle: got %b want 0", pm_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    tests++; if (editing !== 1'b0 || field_sel !== 2'd0 || load_valid !== 1'b0) begin
      fails++; $display("FAIL pm_commit_state: got ed=%b fs=%0d lv=%b want 0/0/0", editing, field_sel, load_valid); end
    tick();
    tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL pm_lv: got %b want 1", load_valid); end
    tests++; if (BCD_load !== 24'h090030) begin fails++; $display("FAIL pm_load: got %h want 090030", BCD_load); end
    tick();
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL pm_lv_once: got %b want 0", load_valid); end
    tests++; if (BCD_load !== 24'h090030) begin fails++; $display("FAIL pm_load_hold: got %h want 090030", BCD_load); end
    tests++; if (editing !== 1'b0) begin fails++; $display("FAIL pm_no_reenter: got %b want 0", editing); end
    set_mode = 1'b0;
    tick();
  endtask

  task automatic test_hour12();
    toggle_ampm = 1'b1; BCD_cur = 24'h110000; set_mode = 1'b1;
    tick();
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h120000 || pm_edit !== 1'b0) begin
      fails++; $display("FAIL h12_inc_11: got %h pm=%b want 120000 pm=0", BCD_edit, pm_edit); end
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h010000) begin fails++; $display("FAIL h12_inc_12: got %h want 010000", BCD_edit); end
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (BCD_edit !== 24'h120000) begin fails++; $display("FAIL h12_dec_01: got %h want 120000", BCD_edit); end
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (BCD_edit !== 24'h110000) begin fails++; $display("FAIL h12_dec_12: got %h want 110000", BCD_edit); end
    pulse(1'b1, 1'b1, 1'b0);
    tests++; if (field_sel !== 2'd1 || BCD_edit !== 24'h110000) begin
      fails++; $display("FAIL next_priority: got fs=%0d %h want 1 110000", field_sel, BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    toggle_ampm = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h110000 || field_sel !== 2'd3) begin
      fails++; $display("FAIL mer_ignore_24h: got %h fs=%0d want 110000 3", BCD_edit, field_sel); end
    toggle_ampm = 1'b1; #1;
    tests++; if (pm_edit !== 1'b0) begin fails++; $display("FAIL mer_ignore_pm: got %b want 0", pm_edit); end
    set_mode = 1'b0;
    tick();
    tests++; if (editing !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b want 0", editing); end
    tick();
    tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL abort_lv: got %b want 0", load_valid); end
    tests++; if (BCD_load !== 24'h090030) begin fails++; $display("FAIL abort_load: got %h want 090030", BCD_load); end
  endtask

  task automatic test_24h_commit();
    toggle_ampm = 1'b0; BCD_cur = 24'h235959; set_mode = 1'b1;
    tick();
    tests++; if (BCD_edit !== 24'h235959 || pm_edit !== 1'b0) begin
      fails++; $display("FAIL h24_cap: got %h pm=%b want 235959 pm=0", BCD_edit, pm_edit); end
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h005959) begin fails++; $display("FAIL h24_hour_wrap: got %h want 005959", BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h000059) begin fails++; $display("FAIL h24_min_wrap: got %h want 000059", BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h000000) begin fails++; $display("FAIL h24_sec_wrap: got %h want 000000", BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    tests++; if (editing !== 1'b0 || field_sel !== 2'd0) begin
      fails++; $display("FAIL h24_skip_mer: got ed=%b fs=%0d want 0/0", editing, field_sel); end
    tick();
    tests++; if (load_valid !== 1'b1 || BCD_load !== 24'h000000) begin
      fails++; $display("FAIL h24_load: got lv=%b %h want 1 000000", load_valid, BCD_load); end
    set_mode = 1'b0;
    tick();
  endtask

  task automatic test_min_dec_both();
    toggle_ampm = 1'b1; BCD_cur = 24'h120000; set_mode = 1'b1;
    tick();
    tests++; if (BCD_edit !== 24'h120000 || pm_edit !== 1'b1) begin
      fails++; $display("FAIL noon_cap: got %h pm=%b want 120000 pm=1", BCD_edit, pm_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (BCD_edit !== 24'h125900) begin fails++; $display("FAIL min_borrow: got %h want 125900", BCD_edit); end
    pulse(1'b0, 1'b1, 1'b1);
    tests++; if (BCD_edit !== 24'h125900) begin fails++; $display("FAIL inc_dec_both: got %h want 125900", BCD_edit); end
    set_mode = 1'b0;
    tick();
  endtask

  task automatic test_hour24_steps();
    toggle_ampm = 1'b0; BCD_cur = 24'h000000; set_mode = 1'b1;
    tick();
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (BCD_edit !== 24'h230000) begin fails++; $display("FAIL h24_dec_00: got %h want 230000", BCD_edit); end
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h000000) begin fails++; $display("FAIL h24_inc_23: got %h want 000000", BCD_edit); end
    set_mode = 1'b0;
    tick();
    BCD_cur = 24'h110009; set_mode = 1'b1;
    tick();
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h120009) begin fails++; $display("FAIL h24_inc_11: got %h want 120009", BCD_edit); end
    toggle_ampm = 1'b1; #1;
    tests++; if (BCD_edit !== 24'h120009 || pm_edit !== 1'b1) begin
      fails++; $display("FAIL h24_to_12pm: got %h pm=%b want 120009 pm=1", BCD_edit, pm_edit); end
    toggle_ampm = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    tests++; if (BCD_edit !== 24'h120010) begin fails++; $display("FAIL sec_carry: got %h want 120010", BCD_edit); end
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (BCD_edit !== 24'h120008) begin fails++; $display("FAIL sec_dec: got %h want 120008", BCD_edit); end
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    tests++; if (load_valid !== 1'b1 || BCD_load !== 24'h120008) begin
      fails++; $display("FAIL noon_load: got lv=%b %h want 1 120008", load_valid, BCD_load); end
    set_mode = 1'b0;
    tick();
  endtask

  task automatic test_invalid_idle();
    toggle_ampm = 1'b1; BCD_cur = 24'h2A0000; set_mode = 1'b1;
    tick();
    tests++; if (BCD_edit !== 24'h120000 || pm_edit !== 1'b0) begin
      fails++; $display("FAIL cap_nonbcd: got %h pm=%b want 120000 pm=0", BCD_edit, pm_edit); end
    set_mode = 1'b0;
    tick();
    BCD_cur = 24'h240000; set_mode = 1'b1;
    tick();
    tests++; if (BCD_edit !== 24'h120000 || pm_edit !== 1'b0) begin
      fails++; $display("FAIL cap_over23: got %h pm=%b want 120000 pm=0", BCD_edit, pm_edit); end
    set_mode = 1'b0;
    tick();
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    tests++; if (editing !== 1'b0 || load_valid !== 1'b0 || BCD_edit !== 24'h120000) begin
      fails++; $display("FAIL idle_ignore: got ed=%b lv=%b %h want 0 0 120000", editing, load_valid, BCD_edit); end
  endtask

  task automatic test_reset_mid();
    toggle_ampm = 1'b1; BCD_cur = 24'h083015; set_mode = 1'b1;
    tick();
    tests++; if (editing !== 1'b1 || BCD_edit !== 24'h083015) begin
      fails++; $display("FAIL mid_cap: got ed=%b %h want 1 083015", editing, BCD_edit); end
    rst = 1'b1; #1;
    tests++; if (editing !== 1'b0 || load_valid !== 1'b0) begin
      fails++; $display("FAIL mid_rst_async: got ed=%b lv=%b want 0 0", editing, load_valid); end
    tests++; if (BCD_load !== 24'h000000 || BCD_edit !== 24'h120000) begin
      fails++; $display("FAIL mid_rst_regs: got load=%h edit=%h want 000000 120000", BCD_load, BCD_edit); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    tests++; if (editing !== 1'b0 || load_valid !== 1'b0) begin
      fails++; $display("FAIL no_edge_after_rst: got ed=%b lv=%b want 0 0", editing, load_valid); end
    set_mode = 1'b0;
    tick();
    set_mode = 1'b1;
    tick();
    tests++; if (editing !== 1'b1 || BCD_edit !== 24'h083015) begin
      fails++; $display("FAIL fresh_edge: got ed=%b %h want 1 083015", editing, BCD_edit); end
    set_mode = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_ampm_commit();
    test_hour12();
    test_24h_commit();
    test_min_dec_both();
    test_hour24_steps();
    test_invalid_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
